// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller.
// Boot, fetch, redirects, stalls with watchdog, traps and halt.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned MAX_STALL    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic        mret,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_next,
  output logic        pc_write_en,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        trap_active,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_TRAP  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [15:0] WD_LAST = 16'(MAX_STALL - 1);

  state_e      fsm_q, fsm_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] pc_inc;
  logic [31:0] redir;

  assign pc_inc = pc + 32'd4;
  assign epc    = epc_q;
  assign cause  = cause_q;

  // State register, saved trap context and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= S_BOOT;
      epc_q       <= '0;
      cause_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and same-cycle PC selection.
  always_comb begin
    fsm_d       = fsm_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    stall_cnt_d = '0;
    pc_next     = pc;
    pc_write_en = 1'b0;
    trap_active = 1'b0;
    halted      = 1'b0;
    redir       = jump ? jump_target : branch_target;
    unique case (fsm_q)
      S_BOOT: begin
        pc_next     = RESET_VECTOR;
        pc_write_en = 1'b1;
        fsm_d       = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (trap_req) begin
          epc_d   = pc;
          cause_d = 2'd1;
          fsm_d   = S_TRAP;
        end else if (stall_req && stall_cnt_q == WD_LAST) begin
          epc_d   = pc;
          cause_d = 2'd3;
          fsm_d   = S_TRAP;
        end else if (halt_req) begin
          fsm_d = S_HALT;
        end else if (stall_req) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
          fsm_d       = S_STALL;
        end else if (mret) begin
          pc_next     = epc_q;
          pc_write_en = 1'b1;
          cause_d     = 2'd0;
          fsm_d       = S_RUN;
        end else if (jump || branch_taken) begin
          if (redir[1:0] != 2'b00) begin
            epc_d   = pc;
            cause_d = 2'd2;
            fsm_d   = S_TRAP;
          end else begin
            pc_next     = redir;
            pc_write_en = 1'b1;
            fsm_d       = S_RUN;
          end
        end else begin
          pc_next     = pc_inc;
          pc_write_en = 1'b1;
          fsm_d       = S_RUN;
        end
      end
      S_TRAP: begin
        pc_next     = TRAP_VECTOR;
        pc_write_en = 1'b1;
        trap_active = 1'b1;
        fsm_d       = S_RUN;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          pc_next     = pc_inc;
          pc_write_en = 1'b1;
          fsm_d       = S_RUN;
        end
      end
      default: begin
        fsm_d = S_BOOT;
      end
    endcase
  end

endmodule
